fifo_wr_arb: RTL and testbench

//  Write-side arbiter for the async FIFO: shares the single FIFO write port
//  (winc/wdata, throttled by wfull) among NREQ requesters in the write domain.

---
 rtl/fifo_wr_arb.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-granular arbiter sharing one async-FIFO write port among NREQ requesters.
// A grant lasts until last, MAXBURST words, or IDLE_TO idle cycles; wfull stalls the owner without ending its grant.
module fifo_wr_arb #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8,
  parameter int IDLE_TO  = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = $clog2(IDLE_TO + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic            xfer;
  logic            end_burst;

  // Scan starting at rr_ptr so the requester after the last owner wins ties.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NREQ;
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(cand);
      end
    end
  end

  assign busy      = (state_q == ST_BURST);
  assign gnt       = gnt_q;
  assign xfer      = busy & req_valid[gidx_q] & ~wfull;
  assign winc      = xfer;
  assign req_ready = xfer ? gnt_q : '0;
  assign wdata     = busy ? req_data[int'(gidx_q)*DSIZE +: DSIZE] : '0;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    end_burst   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d     = ST_BURST;
          gidx_d      = pick_idx;
          gnt_d       = NREQ'(1) << pick_idx;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      ST_BURST: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          idle_cnt_d  = '0;
          if (req_last[gidx_q] || (burst_cnt_q == 8'(MAXBURST - 1)))
            end_burst = 1'b1;
        end else if (!wfull) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == IW'(IDLE_TO - 1))
            end_burst = 1'b1;
        end
        if (end_burst) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
          rr_ptr_d    = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: fixed vector table, directed burst scenarios, random run against a queue model.
module tb_fifo_wr_arb;
  localparam int DSIZE = 8, NREQ = 4, MAXBURST = 8, IDLE_TO = 4;

  logic                  wclk = 1'b0;
  logic                  wrst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0, req_last = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic                  wfull = 1'b0;
  logic [NREQ-1:0]       req_ready, gnt;
  logic                  winc, busy;
  logic [DSIZE-1:0]      wdata;

  always #5 wclk = ~wclk;

  fifo_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST), .IDLE_TO(IDLE_TO)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .gnt(gnt), .busy(busy));

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit rst; bit [3:0] vld; bit [3:0] lst; bit full;
    bit [3:0] e_gnt; bit e_winc; bit [3:0] e_rdy; bit e_busy; bit [7:0] e_wd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit [3:0] vld, bit [3:0] lst, bit full,
                              bit [3:0] g, bit w, bit [3:0] r, bit b, bit [7:0] wd);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.full = full;
    v.e_gnt = g; v.e_winc = w; v.e_rdy = r; v.e_busy = b; v.e_wd = wd;
    return v;
  endfunction

  typedef struct { bit [7:0] d; bit l; } word_t;
  word_t q[NREQ][$];
  bit    pres[NREQ];
  int    seq[NREQ];
  int    m_own, m_ptr, m_words, m_idle;
  int    gap_pct;
  int    lg_gnt[$];
  bit    lg_winc[$];
  int    bl[$];

  task automatic model_release();
    m_ptr = (m_own + 1) % NREQ;
    m_own = -1; m_words = 0; m_idle = 0;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin q[i].delete(); pres[i] = 0; seq[i] = 0; end
    m_own = -1; m_ptr = 0; m_words = 0; m_idle = 0;
    lg_gnt.delete(); lg_winc.delete();
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
  endtask

  task automatic push_word(input int i, input bit last);
    word_t w;
    w.d = 8'(i * 64 + seq[i] % 64);
    w.l = last;
    q[i].push_back(w);
    seq[i]++;
  endtask

  // One cycle: drive requesters, compare against the model mid-cycle, advance the model on the edge.
  task automatic step(input bit full);
    bit [NREQ-1:0] e_gnt, e_rdy;
    bit            e_winc, found, last;
    bit [7:0]      e_wd;
    int            idx;
    for (int i = 0; i < NREQ; i++) begin
      if (!pres[i] && q[i].size() > 0 && $urandom_range(99) >= gap_pct) pres[i] = 1;
      req_valid[i] = pres[i];
      req_last[i]  = pres[i] ? q[i][0].l : 1'b0;
      req_data[i*DSIZE +: DSIZE] = pres[i] ? q[i][0].d : 8'h00;
    end
    wfull  = full;
    e_gnt  = (m_own >= 0) ? NREQ'(1) << m_own : '0;
    e_winc = (m_own >= 0) && pres[m_own] && !full;
    e_rdy  = e_winc ? e_gnt : '0;
    e_wd   = (m_own >= 0) ? req_data[m_own*DSIZE +: DSIZE] : 8'h00;
    @(negedge wclk);
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("winc", 32'(winc), 32'(e_winc));
    check("req_ready", 32'(req_ready), 32'(e_rdy));
    check("busy", 32'(busy), 32'(m_own >= 0));
    check("wdata", 32'(wdata), 32'(e_wd));
    check("write_while_full", 32'(winc & wfull), 32'd0);
    lg_gnt.push_back(int'(gnt));
    lg_winc.push_back(winc);
    @(posedge wclk);
    if (m_own < 0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && pres[idx]) begin found = 1; m_own = idx; m_words = 0; m_idle = 0; end
      end
    end else if (e_winc) begin
      last = q[m_own][0].l;
      void'(q[m_own].pop_front());
      pres[m_own] = 0;
      m_words++; m_idle = 0;
      if (last || m_words == MAXBURST) model_release();
    end else if (!full) begin
      m_idle++;
      if (m_idle == IDLE_TO) model_release();
    end
    #1;
  endtask

  task automatic burst_lens(input int g);
    int cnt; bit inside_g;
    cnt = 0; inside_g = 0; bl.delete();
    for (int j = 0; j < lg_gnt.size(); j++) begin
      if (lg_gnt[j] == g) begin inside_g = 1; cnt += int'(lg_winc[j]); end
      else if (inside_g) begin bl.push_back(cnt); cnt = 0; inside_g = 0; end
    end
    if (inside_g) bl.push_back(cnt);
  endtask

  initial begin
    int exp3[3];
    int tail, nxt, left, stall_cnt;
    bit seen;

    // Reset with everyone requesting, round robin with last on every word, a wfull stall, reset mid-burst.
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h1, 1, 4'h1, 1, 8'hA0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h2, 1, 4'h2, 1, 8'hB1));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h4, 1, 4'h4, 1, 8'hC2));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h8, 1, 4'h8, 1, 8'hD3));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 4'h1, 0, 4'h0, 1, 8'hA0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h1, 1, 4'h1, 1, 8'hA0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'h0, 0, 4'h2, 1, 4'h2, 1, 8'hB1));
    tbl.push_back(mk(0, 4'hF, 4'h0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'h0, 0, 4'h0, 0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(1, 4'hF, 4'h0, 0, 4'h1, 1, 4'h1, 1, 8'hA0));

    #1;
    req_data = 32'hD3C2B1A0;
    for (int r = 0; r < tbl.size(); r++) begin
      wrst_n = tbl[r].rst; req_valid = tbl[r].vld; req_last = tbl[r].lst; wfull = tbl[r].full;
      @(negedge wclk);
      check($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(tbl[r].e_gnt));
      check($sformatf("tbl%0d_winc", r), 32'(winc), 32'(tbl[r].e_winc));
      check($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
      check($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
      check($sformatf("tbl%0d_wdata", r), 32'(wdata), 32'(tbl[r].e_wd));
      @(posedge wclk);
      #1;
    end

    // Long burst on req 1 is cut at MAXBURST, req 3 gets a turn in between.
    do_reset(); gap_pct = 0;
    for (int k = 0; k < 20; k++) push_word(1, 1'b0);
    for (int k = 0; k < 2; k++) push_word(3, 1'b1);
    repeat (60) step(1'b0);
    burst_lens(2);
    exp3 = '{8, 8, 4};
    check("maxburst_ngrants", 32'(bl.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("maxburst_len%0d", k), 32'(k < bl.size() ? bl[k] : -1), 32'(exp3[k]));
    check("maxburst_drained", 32'(q[1].size() + q[3].size()), 32'd0);

    // FIFO full for 10 cycles after the first word: grant held, word count kept across the stall.
    do_reset(); gap_pct = 0;
    for (int k = 0; k < 10; k++) push_word(0, 1'b0);
    repeat (2) step(1'b0);
    repeat (10) step(1'b1);
    repeat (30) step(1'b0);
    stall_cnt = 0;
    for (int j = 2; j < 12; j++) if (lg_gnt[j] == 1 && !lg_winc[j]) stall_cnt++;
    check("stall_hold_cycles", 32'(stall_cnt), 32'd10);
    burst_lens(1);
    check("stall_ngrants", 32'(bl.size()), 32'd2);
    check("stall_len0", 32'(bl.size() > 0 ? bl[0] : -1), 32'd8);
    check("stall_len1", 32'(bl.size() > 1 ? bl[1] : -1), 32'd2);

    // Owner goes quiet after 2 words: released after IDLE_TO idle cycles, req 2 is next.
    do_reset(); gap_pct = 0;
    for (int k = 0; k < 2; k++) push_word(0, 1'b0);
    for (int k = 0; k < 3; k++) push_word(2, k == 2);
    repeat (20) step(1'b0);
    tail = 0; nxt = 0; seen = 0;
    for (int j = 0; j < lg_gnt.size(); j++) begin
      if (lg_gnt[j] == 1) begin seen = 1; tail = lg_winc[j] ? 0 : tail + 1; end
      else if (seen && lg_gnt[j] != 0 && nxt == 0) nxt = lg_gnt[j];
    end
    check("timeout_idle_cycles", 32'(tail), 32'(IDLE_TO));
    check("timeout_next_gnt", 32'(nxt), 32'h4);

    // Random traffic and wfull against the model, then drain.
    do_reset(); gap_pct = 30;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) if (q[i].size() < 2) push_word(i, $urandom_range(3) == 0);
      step($urandom_range(99) < 25);
    end
    gap_pct = 0;
    for (int c = 0; c < 300; c++) begin
      left = 0;
      for (int i = 0; i < NREQ; i++) left += q[i].size();
      if (left != 0) step(1'b0);
    end
    left = 0;
    for (int i = 0; i < NREQ; i++) left += q[i].size();
    check("random_drained", 32'(left), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
